display_scan_ctrl: RTL and testbench

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/display_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 7-segment scan controller.
// Walks a digit select across NUM_DIGITS positions, one slot of PRESCALE
// clocks per digit. Each slot opens with BLANK_CYCLES of decoder-off time so
// the previous digit's segments fade before the next select line is driven.
// Digit values are captured once per frame so a frame never mixes old and
// new data. Every output is a flop fed from the next-state logic.
module display_scan_ctrl #(
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2,
    parameter int NUM_DIGITS   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [31:0] digits,
    input  logic [7:0]  blink_mask,
    input  logic        blink_tick,
    output logic [2:0]  S,
    output logic        enable,
    output logic [3:0]  bcd,
    output logic        frame_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    // Last counter value of a slot, number of dark cycles, last digit index.
    localparam logic [15:0] CNT_LAST  = 16'(PRESCALE - 1);
    localparam logic [15:0] BLANK_LEN = 16'(BLANK_CYCLES);
    localparam logic [2:0]  S_LAST    = 3'(NUM_DIGITS - 1);

    // State entered at the start of every slot: dark first unless no blanking.
    localparam logic [1:0] ST_SLOT_START = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    logic [1:0]  state;
    logic [15:0] cnt;
    logic [31:0] snapshot;
    logic        blink_phase;

    logic [1:0]  state_nx;
    logic [15:0] cnt_nx;
    logic [2:0]  s_nx;
    logic [31:0] snap_nx;
    logic        phase_nx;
    logic        fd_nx;
    logic        en_nx;
    logic [3:0]  bcd_nx;

    // Next-state logic: slot timing, digit advance, frame reload and output
    // values are all derived here so the output flops see the values that
    // belong to the upcoming cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        s_nx     = S;
        snap_nx  = snapshot;
        fd_nx    = 1'b0;
        // The blink phase keeps toggling even while idle or stopped.
        phase_nx = blink_phase ^ blink_tick;

        if (!run) begin
            // Stopping always wins, including on the last cycle of a frame.
            state_nx = ST_IDLE;
            cnt_nx   = 16'd0;
            s_nx     = 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Starting a scan captures a fresh frame of digits.
                    state_nx = ST_SLOT_START;
                    cnt_nx   = 16'd0;
                    s_nx     = 3'd0;
                    snap_nx  = digits;
                end
                ST_BLANK, ST_SHOW: begin
                    if (cnt == CNT_LAST) begin
                        cnt_nx   = 16'd0;
                        state_nx = ST_SLOT_START;
                        if (S >= S_LAST) begin
                            // Frame boundary: wrap and take the new digits.
                            s_nx    = 3'd0;
                            snap_nx = digits;
                            fd_nx   = 1'b1;
                        end else begin
                            s_nx = S + 3'd1;
                        end
                    end else begin
                        cnt_nx   = cnt + 16'd1;
                        state_nx = (cnt_nx < BLANK_LEN) ? ST_BLANK : ST_SHOW;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = 16'd0;
                    s_nx     = 3'd0;
                end
            endcase
        end

        // Decoder lights only in the visible part of a slot, and a blinking
        // digit goes dark while the blink phase is set.
        en_nx  = (state_nx == ST_SHOW) && !(blink_mask[s_nx] && phase_nx);
        bcd_nx = snap_nx[{s_nx, 2'b00} +: 4];
    end

    // Register state, counters, snapshot and all outputs; reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cnt         <= 16'd0;
            snapshot    <= 32'd0;
            blink_phase <= 1'b0;
            S           <= 3'd0;
            enable      <= 1'b0;
            bcd         <= 4'd0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            snapshot    <= snap_nx;
            blink_phase <= phase_nx;
            S           <= s_nx;
            enable      <= en_nx;
            bcd         <= bcd_nx;
            frame_done  <= fd_nx;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: two instances (with and without blanking)
// driven from the same stimulus and compared every cycle against a model
// that tracks elapsed scan time, plus directed sequences with literal values.
module tb_display_scan_ctrl;

    localparam int P = 4;
    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [31:0] digits;
    logic [7:0]  blink_mask;
    logic        blink_tick;

    logic [2:0]  s0, s1;
    logic        en0, en1, fd0, fd1;
    logic [3:0]  bcd0, bcd1;

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    display_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(1), .NUM_DIGITS(N)) dut0 (
        .clk(clk), .rst_n(rst_n), .run(run), .digits(digits),
        .blink_mask(blink_mask), .blink_tick(blink_tick),
        .S(s0), .enable(en0), .bcd(bcd0), .frame_done(fd0)
    );

    display_scan_ctrl #(.PRESCALE(P), .BLANK_CYCLES(0), .NUM_DIGITS(N)) dut1 (
        .clk(clk), .rst_n(rst_n), .run(run), .digits(digits),
        .blink_mask(blink_mask), .blink_tick(blink_tick),
        .S(s1), .enable(en1), .bcd(bcd1), .frame_done(fd1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: time elapsed since the scan started, captured frame,
    // blink phase. Outputs follow from plain division/modulo of the time.
    bit          m_active, m_phase, m_fd;
    int          m_t;
    logic [31:0] m_snap;
    logic [7:0]  m_mask;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_phase = 0; m_fd = 0; m_t = 0;
            m_snap = '0; m_mask = '0;
        end else begin
            m_phase = m_phase ^ blink_tick;
            m_mask  = blink_mask;
            m_fd    = 0;
            if (!run) begin
                m_active = 0;
                m_t = 0;
            end else if (!m_active) begin
                m_active = 1;
                m_t = 0;
                m_snap = digits;
            end else begin
                m_t++;
                if (m_t % (P * N) == 0) begin
                    m_snap = digits;
                    m_fd = 1;
                end
            end
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        int s, pos;
        bit dark;
        if (chk_on) begin
            s    = m_active ? (m_t / P) % N : 0;
            pos  = m_active ? m_t % P : 0;
            dark = m_mask[s] && m_phase;
            chk("model_S_b1", s0, s);
            chk("model_S_b0", s1, s);
            chk("model_en_b1", en0, m_active && pos >= 1 && !dark);
            chk("model_en_b0", en1, m_active && !dark);
            chk("model_bcd_b1", bcd0, m_snap[4*s +: 4]);
            chk("model_bcd_b0", bcd1, m_snap[4*s +: 4]);
            chk("model_fd_b1", fd0, m_fd);
            chk("model_fd_b0", fd1, m_fd);
        end
    end

    initial begin
        int tab_a[3];
        int tab_b[3];
        int sl;
        bit ph;
        tab_a = '{7, 8, 9};
        tab_b = '{1, 2, 3};
        rst_n = 1'b0; run = 1'b0; digits = 32'h0000_0987;
        blink_mask = 8'h00; blink_tick = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_S", s0, 0);     chk("rst_en", en0, 0);
        chk("rst_bcd", bcd0, 0); chk("rst_fd", fd0, 0);
        chk("rst_en_b0", en1, 0); chk("rst_bcd_b0", bcd1, 0);
        rst_n = 1'b1;
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_S", s0, 0); chk("idle_en", en0, 0); chk("idle_en_b0", en1, 0);

        // Basic scan, snapshot hold, blink on digit 1, then abort mid-slot.
        run = 1'b1;
        for (int c = 0; c < 67; c++) begin
            @(negedge clk);
            blink_tick = 1'b0;
            sl = (c / 4) % 3;
            ph = (c >= 36 && c < 48);
            chk("lit_S", s0, sl);
            chk("lit_S_b0", s1, sl);
            chk("lit_en", en0, (c % 4 != 0) && !(ph && sl == 1));
            chk("lit_en_b0", en1, !(ph && sl == 1));
            chk("lit_bcd", bcd0, (c < 24) ? tab_a[sl] : tab_b[sl]);
            chk("lit_bcd_b0", bcd1, (c < 24) ? tab_a[sl] : tab_b[sl]);
            chk("lit_fd", fd0, (c > 0) && (c % 12 == 0));
            if (c == 17) digits = 32'h0000_0321;
            if (c == 35 || c == 47) begin
                blink_mask = 8'h02;
                blink_tick = 1'b1;
            end
            if (c == 66) run = 1'b0;
        end
        @(negedge clk);
        chk("abort_S", s0, 0); chk("abort_en", en0, 0);
        chk("abort_fd", fd0, 0); chk("abort_en_b0", en1, 0);
        run = 1'b1;
        @(negedge clk);
        chk("restart_S", s0, 0); chk("restart_en", en0, 0);
        chk("restart_en_b0", en1, 1); chk("restart_bcd", bcd0, 1);
        @(negedge clk);
        chk("restart_show", en0, 1);

        // Asynchronous reset in the middle of the visible part of a slot.
        #2 rst_n = 1'b0;
        #1;
        chk("arst_en", en0, 0); chk("arst_S", s0, 0);
        chk("arst_bcd", bcd0, 0); chk("arst_en_b0", en1, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random run/blink/digit traffic with rare asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            run = ($urandom_range(99) < 96);
            blink_tick = ($urandom_range(99) < 6);
            if ($urandom_range(99) < 5) blink_mask = 8'($urandom);
            if ($urandom_range(99) < 4) digits = $urandom;
            if ($urandom_range(999) < 3) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rnd_arst_en", en0, 0);
                chk("rnd_arst_S", s1, 0);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
